// File: rtl/ulpi_reg_access_pkg.sv
// Shared definitions for the ULPI register-access controller: TX CMD prefixes,
// RX CMD field positions and the FSM state type.
package ulpi_reg_access_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;

  localparam logic [1:0]        TXCMD_WRITE = 2'b10;
  localparam logic [1:0]        TXCMD_READ  = 2'b11;
  localparam logic [DATA_W-1:0] BUS_IDLE    = 8'h00;

  localparam int unsigned RXCMD_LINESTATE_LSB = 0;
  localparam int unsigned RXCMD_LINESTATE_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TXCMD,
    ST_WDATA,
    ST_STP,
    ST_RD_TURN1,
    ST_RD_DATA,
    ST_RD_TURN2,
    ST_ABORT
  } state_e;

  function automatic logic [DATA_W-1:0] txcmd_byte(input logic write, input logic [ADDR_W-1:0] addr);
    return {(write ? TXCMD_WRITE : TXCMD_READ), addr};
  endfunction

endpackage

// File: rtl/ulpi_reg_access_if.sv
// Single-request register port between the USB core (master) and the ULPI
// register-access controller (slave).
interface ulpi_reg_access_if;
  import ulpi_reg_access_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_abort;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_abort, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_abort, rsp_rdata
  );

endinterface

// File: rtl/ulpi_reg_access.sv
// Link-side ULPI controller: PHY register read/write over the 8-bit ULPI bus
// with abort/retry, plus RX CMD capture whenever the PHY owns the bus idle.
module ulpi_reg_access
  import ulpi_reg_access_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic              ulpi_clk,
  input  logic              ulpi_reset_n,
  input  logic [DATA_W-1:0] ulpi_data_in,
  output logic [DATA_W-1:0] ulpi_data_out,
  output logic              ulpi_data_oe,
  input  logic              ulpi_direction,
  input  logic              ulpi_nxt,
  output logic              ulpi_stp,
  ulpi_reg_access_if.slave  req_if,
  output logic              rx_cmd_valid,
  output logic [DATA_W-1:0] rx_cmd,
  output logic [1:0]        linestate
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_e              state_q, state_d;
  logic                dir_q;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                stp_q, stp_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_abort_q, rsp_abort_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rx_cmd_valid_q, rx_cmd_valid_d;
  logic [DATA_W-1:0]   rx_cmd_q, rx_cmd_d;
  logic [1:0]          linestate_q, linestate_d;
  logic [RETRY_W-1:0]  retries_q, retries_d;
  logic                req_write_q, req_write_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;

  logic                bus_free;
  logic                req_ready_c;
  logic                accept;
  logic [DATA_W-1:0]   cmd_byte;

  // The link may drive only when the PHY has released the bus for a full cycle.
  assign bus_free     = ~ulpi_direction & ~dir_q;
  assign ulpi_data_oe = bus_free;
  // Gated by reset so the port reads not-ready while reset is held.
  assign req_ready_c  = ulpi_reset_n & bus_free & (state_q == ST_IDLE);
  assign accept       = req_if.req_valid & req_ready_c;
  assign cmd_byte     = txcmd_byte(req_write_q, req_addr_q);

  assign req_if.req_ready = req_ready_c;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_abort = rsp_abort_q;
  assign req_if.rsp_rdata = rsp_rdata_q;
  assign ulpi_data_out    = data_out_q;
  assign ulpi_stp         = stp_q;
  assign rx_cmd_valid     = rx_cmd_valid_q;
  assign rx_cmd           = rx_cmd_q;
  assign linestate        = linestate_q;

  always_comb begin
    state_d        = state_q;
    data_out_d     = data_out_q;
    stp_d          = 1'b0;
    rsp_valid_d    = 1'b0;
    rsp_abort_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
    retries_d      = retries_q;
    req_write_d    = req_write_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    rx_cmd_valid_d = 1'b0;
    rx_cmd_d       = rx_cmd_q;
    linestate_d    = linestate_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_write_d = req_if.req_write;
          req_addr_d  = req_if.req_addr;
          req_wdata_d = req_if.req_wdata;
          data_out_d  = txcmd_byte(req_if.req_write, req_if.req_addr);
          state_d     = ST_TXCMD;
        end
      end
      ST_TXCMD: begin
        if (ulpi_direction) begin
          data_out_d = BUS_IDLE;
          state_d    = ST_ABORT;
        end else if (ulpi_nxt) begin
          if (req_write_q) begin
            data_out_d = req_wdata_q;
            state_d    = ST_WDATA;
          end else begin
            data_out_d = BUS_IDLE;
            state_d    = ST_RD_TURN1;
          end
        end
      end
      ST_WDATA: begin
        if (ulpi_direction) begin
          data_out_d = BUS_IDLE;
          state_d    = ST_ABORT;
        end else if (ulpi_nxt) begin
          data_out_d = BUS_IDLE;
          stp_d      = 1'b1;
          state_d    = ST_STP;
        end
      end
      ST_STP: begin
        rsp_valid_d = 1'b1;
        retries_d   = '0;
        state_d     = ST_IDLE;
      end
      ST_RD_TURN1: begin
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (ulpi_direction && !ulpi_nxt) begin
          rsp_rdata_d = ulpi_data_in;
          rsp_valid_d = 1'b1;
          retries_d   = '0;
          state_d     = ST_RD_TURN2;
        end else begin
          data_out_d = BUS_IDLE;
          state_d    = ST_ABORT;
        end
      end
      ST_RD_TURN2: begin
        if (!ulpi_direction) begin
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: begin
        data_out_d = BUS_IDLE;
        // Retry only once the bus has been back with the link for a full cycle.
        if (bus_free) begin
          if (32'(retries_q) < MAX_RETRY) begin
            retries_d  = retries_q + RETRY_W'(1);
            data_out_d = cmd_byte;
            state_d    = ST_TXCMD;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_abort_d = 1'b1;
            retries_d   = '0;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // RX CMD: PHY owns the bus past turnaround with nxt low; RD_DATA owns that byte.
    if (ulpi_direction && dir_q && !ulpi_nxt && (state_q != ST_RD_DATA)) begin
      rx_cmd_d       = ulpi_data_in;
      linestate_d    = ulpi_data_in[RXCMD_LINESTATE_LSB +: RXCMD_LINESTATE_W];
      rx_cmd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge ulpi_clk or negedge ulpi_reset_n) begin
    if (!ulpi_reset_n) begin
      state_q        <= ST_IDLE;
      dir_q          <= 1'b0;
      data_out_q     <= BUS_IDLE;
      stp_q          <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_abort_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rx_cmd_valid_q <= 1'b0;
      rx_cmd_q       <= '0;
      linestate_q    <= '0;
      retries_q      <= '0;
      req_write_q    <= 1'b0;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      dir_q          <= ulpi_direction;
      data_out_q     <= data_out_d;
      stp_q          <= stp_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_abort_q    <= rsp_abort_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rx_cmd_valid_q <= rx_cmd_valid_d;
      rx_cmd_q       <= rx_cmd_d;
      linestate_q    <= linestate_d;
      retries_q      <= retries_d;
      req_write_q    <= req_write_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
    end
  end

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed bench for ulpi_reg_access: an event-level model of bus bytes, stp,
// responses and RX CMDs, checked every cycle, plus literal per-cycle pins.
`timescale 1ns/1ps
module tb_ulpi_reg_access;
  import ulpi_reg_access_pkg::*;

  localparam int unsigned MAXR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe;
  logic       dir = 1'b0;
  logic       nxt = 1'b0;
  logic       stp;
  logic       rx_cmd_valid;
  logic [7:0] rx_cmd;
  logic [1:0] linestate;

  ulpi_reg_access_if u_if ();

  ulpi_reg_access #(.MAX_RETRY(MAXR)) dut (
    .ulpi_clk       (clk),
    .ulpi_reset_n   (rst_n),
    .ulpi_data_in   (data_in),
    .ulpi_data_out  (data_out),
    .ulpi_data_oe   (data_oe),
    .ulpi_direction (dir),
    .ulpi_nxt       (nxt),
    .ulpi_stp       (stp),
    .req_if         (u_if),
    .rx_cmd_valid   (rx_cmd_valid),
    .rx_cmd         (rx_cmd),
    .linestate      (linestate)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: unexpected event @%0t", name, $time);
  endtask

  // ---------------- model: expected event streams ----------------
  typedef struct {
    logic       abort;
    logic       is_read;
    logic [7:0] rdata;
  } rsp_t;

  localparam logic [8:0] STP_EV = 9'h100;   // {stp, data_out} while stp is high
  logic [8:0] exp_bus[$];
  rsp_t       exp_rsp[$];
  logic [7:0] exp_rx[$];

  function automatic logic [7:0] model_cmd(input logic w, input logic [5:0] a);
    return (w ? 8'h80 : 8'hC0) | {2'b00, a};
  endfunction

  task automatic model_write(input logic [5:0] a, input logic [7:0] d, input int unsigned aborts);
    rsp_t r;
    for (int unsigned i = 0; i < aborts; i++) exp_bus.push_back({1'b0, model_cmd(1'b1, a)});
    exp_bus.push_back({1'b0, model_cmd(1'b1, a)});
    exp_bus.push_back({1'b0, d});
    exp_bus.push_back(STP_EV);
    r.abort = 1'b0; r.is_read = 1'b0; r.rdata = 8'h00;
    exp_rsp.push_back(r);
  endtask

  task automatic model_read(input logic [5:0] a, input logic [7:0] d);
    rsp_t r;
    exp_bus.push_back({1'b0, model_cmd(1'b0, a)});
    r.abort = 1'b0; r.is_read = 1'b1; r.rdata = d;
    exp_rsp.push_back(r);
  endtask

  task automatic model_exhaust(input logic w, input logic [5:0] a);
    rsp_t r;
    for (int unsigned i = 0; i < MAXR + 1; i++) exp_bus.push_back({1'b0, model_cmd(w, a)});
    r.abort = 1'b1; r.is_read = 1'b0; r.rdata = 8'h00;
    exp_rsp.push_back(r);
  endtask

  // ---------------- compare process ----------------
  logic       dir_prev;
  logic [7:0] prev_out = 8'h00;
  logic       prev_stp = 1'b0;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) dir_prev <= 1'b0;
    else        dir_prev <= dir;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("oe_rule", {31'd0, data_oe}, {31'd0, ~dir & ~dir_prev});
      chk("ready_gate", {31'd0, u_if.req_ready & (dir | dir_prev)}, 32'd0);
      if (data_out !== prev_out && data_out !== 8'h00) begin
        if (exp_bus.size() == 0) fail_now("bus_byte_extra");
        else chk("bus_byte", {23'd0, 1'b0, data_out}, {23'd0, exp_bus.pop_front()});
      end
      if (stp) begin
        chk("stp_width", {31'd0, prev_stp}, 32'd0);
        if (exp_bus.size() == 0) fail_now("stp_extra");
        else chk("stp_event", {23'd0, stp, data_out}, {23'd0, exp_bus.pop_front()});
      end
      if (u_if.rsp_valid) begin
        if (exp_rsp.size() == 0) fail_now("rsp_extra");
        else begin
          rsp_t r;
          r = exp_rsp.pop_front();
          chk("rsp_abort", {31'd0, u_if.rsp_abort}, {31'd0, r.abort});
          if (r.is_read) chk("rsp_rdata", {24'd0, u_if.rsp_rdata}, {24'd0, r.rdata});
        end
      end
      if (rx_cmd_valid) begin
        if (exp_rx.size() == 0) fail_now("rx_cmd_extra");
        else begin
          logic [7:0] e;
          e = exp_rx.pop_front();
          chk("rx_cmd", {24'd0, rx_cmd}, {24'd0, e});
          chk("rx_linestate", {30'd0, linestate}, {30'd0, e[1:0]});
        end
      end
    end
    prev_out = data_out;
    prev_stp = stp;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [5:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    u_if.req_valid = 1'b1;
    u_if.req_write = w;
    u_if.req_addr  = a;
    u_if.req_wdata = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (u_if.req_ready) ok = 1'b1;
      step();
    end
    u_if.req_valid = 1'b0;
    chk("issue_accepted", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rsp(input logic exp_abort, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (u_if.rsp_valid) ok = 1'b1;
    end
    chk({name, "_rsp_seen"}, {31'd0, ok}, 32'd1);
    if (ok) chk({name, "_rsp_abort"}, {31'd0, u_if.rsp_abort}, {31'd0, exp_abort});
  endtask

  task automatic wait_out(input logic [7:0] val, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      if (data_out == val) ok = 1'b1;
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    u_if.req_valid = 1'b0;
    u_if.req_write = 1'b0;
    u_if.req_addr  = '0;
    u_if.req_wdata = '0;

    // Reset values
    #12;
    chk("rst_data_out", {24'd0, data_out}, 32'h00);
    chk("rst_stp", {31'd0, stp}, 32'd0);
    chk("rst_ready", {31'd0, u_if.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, u_if.rsp_valid}, 32'd0);
    chk("rst_rsp_abort", {31'd0, u_if.rsp_abort}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, u_if.rsp_rdata}, 32'h00);
    chk("rst_rx_valid", {31'd0, rx_cmd_valid}, 32'd0);
    chk("rst_rx_cmd", {24'd0, rx_cmd}, 32'h00);
    chk("rst_linestate", {30'd0, linestate}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("ready_after_reset", {31'd0, u_if.req_ready}, 32'd1);
    step();

    // T1: write 0x16 <= 0xA5, nxt immediately
    model_write(6'h16, 8'hA5, 0);
    issue(1'b1, 6'h16, 8'hA5);
    nxt = 1'b1;
    chk("t1_cmd", {24'd0, data_out}, 32'h96);
    step();
    chk("t1_wdata", {24'd0, data_out}, 32'hA5);
    step();
    nxt = 1'b0;
    chk("t1_stp", {31'd0, stp}, 32'd1);
    chk("t1_idle_bus", {24'd0, data_out}, 32'h00);
    step();
    chk("t1_rsp_valid", {31'd0, u_if.rsp_valid}, 32'd1);
    chk("t1_rsp_abort", {31'd0, u_if.rsp_abort}, 32'd0);
    step();
    chk("t1_rsp_pulse", {31'd0, u_if.rsp_valid}, 32'd0);
    chk("t1_stp_pulse", {31'd0, stp}, 32'd0);

    // T2: write 0x05 <= 0x3C, nxt delayed 3 cycles on TX CMD, 2 on data
    model_write(6'h05, 8'h3C, 0);
    issue(1'b1, 6'h05, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      chk("t2_cmd_hold", {24'd0, data_out}, 32'h85);
      step();
    end
    nxt = 1'b1;
    chk("t2_cmd_hold", {24'd0, data_out}, 32'h85);
    step();
    nxt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t2_wdata_hold", {24'd0, data_out}, 32'h3C);
      chk("t2_no_early_stp", {31'd0, stp}, 32'd0);
      step();
    end
    nxt = 1'b1;
    chk("t2_wdata_hold", {24'd0, data_out}, 32'h3C);
    step();
    nxt = 1'b0;
    chk("t2_stp", {31'd0, stp}, 32'd1);
    wait_rsp(1'b0, "t2");
    step();

    // T3: read 0x0A, PHY returns 0x5C
    model_read(6'h0A, 8'h5C);
    issue(1'b0, 6'h0A, 8'h00);
    chk("t3_cmd", {24'd0, data_out}, 32'hCA);
    nxt = 1'b1;
    step();
    nxt = 1'b0; dir = 1'b1; data_in = 8'hFF;
    @(negedge clk);
    chk("t3_oe_turn1", {31'd0, data_oe}, 32'd0);
    step();
    data_in = 8'h5C;
    @(negedge clk);
    chk("t3_oe_data", {31'd0, data_oe}, 32'd0);
    step();
    dir = 1'b0; data_in = 8'h00;
    @(negedge clk);
    chk("t3_oe_turn2", {31'd0, data_oe}, 32'd0);
    chk("t3_rsp_valid", {31'd0, u_if.rsp_valid}, 32'd1);
    chk("t3_rdata", {24'd0, u_if.rsp_rdata}, 32'h5C);
    chk("t3_not_ready_turn2", {31'd0, u_if.req_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("t3_oe_back", {31'd0, data_oe}, 32'd1);
    chk("t3_rdata_held", {24'd0, u_if.rsp_rdata}, 32'h5C);
    step();

    // T4: PHY takes the bus during TXCMD with RX CMD 0x4E, then write completes
    model_write(6'h11, 8'h77, 1);
    exp_rx.push_back(8'h4E);
    issue(1'b1, 6'h11, 8'h77);
    dir = 1'b1;
    step();
    data_in = 8'h4E;
    step();
    dir = 1'b0; data_in = 8'h00; nxt = 1'b1;
    chk("t4_rx_valid", {31'd0, rx_cmd_valid}, 32'd1);
    chk("t4_rx_cmd", {24'd0, rx_cmd}, 32'h4E);
    chk("t4_linestate", {30'd0, linestate}, 32'd2);
    wait_rsp(1'b0, "t4");
    nxt = 1'b0;
    step();

    // T5: four consecutive aborts exhaust the retries
    model_exhaust(1'b1, 6'h03);
    issue(1'b1, 6'h03, 8'h5A);
    for (int a = 0; a < int'(MAXR) + 1; a++) begin
      if (a > 0) wait_out(8'h83, "t5_reissue");
      dir = 1'b1; nxt = 1'b0;
      step();
      nxt = 1'b1; data_in = 8'hEE;
      step();
      dir = 1'b0; nxt = 1'b0; data_in = 8'h00;
    end
    wait_rsp(1'b1, "t5");
    step();

    // T6: reset in WDATA, then a fresh write
    exp_bus.push_back({1'b0, model_cmd(1'b1, 6'h20)});
    exp_bus.push_back({1'b0, 8'h11});
    issue(1'b1, 6'h20, 8'h11);
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_stp", {31'd0, stp}, 32'd0);
    chk("t6_rst_data_out", {24'd0, data_out}, 32'h00);
    chk("t6_rst_ready", {31'd0, u_if.req_ready}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    model_write(6'h2A, 8'hC3, 0);
    issue(1'b1, 6'h2A, 8'hC3);
    chk("t6_cmd", {24'd0, data_out}, 32'hAA);
    nxt = 1'b1;
    wait_rsp(1'b0, "t6");
    nxt = 1'b0;
    repeat (4) step();

    chk("bus_events_left", exp_bus.size(), 32'd0);
    chk("rsp_events_left", exp_rsp.size(), 32'd0);
    chk("rx_events_left", exp_rx.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
